mcs51_mcu: RTL and testbench



---
 rtl/mcs51_pkg.sv | 76 +++++++
 rtl/mcs51_alu.sv | 53 +++++
 rtl/mcs51_mcu.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_mcs51_mcu.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mcs51_pkg.sv
// Shared definitions for the mcs51_mcu core: opcodes, SFR map, FSM and ALU encodings.
package mcs51_pkg;

  typedef enum logic [2:0] {FETCH, OPND1, OPND2, EXEC, STK2} state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUBB, ALU_AND, ALU_OR, ALU_XOR, ALU_INC, ALU_DEC, ALU_CPL
  } alu_op_t;

  localparam logic [7:0] OP_NOP         = 8'h00;
  localparam logic [7:0] OP_LJMP        = 8'h02;
  localparam logic [7:0] OP_LCALL       = 8'h12;
  localparam logic [7:0] OP_RET         = 8'h22;
  localparam logic [7:0] OP_INC_A       = 8'h04;
  localparam logic [7:0] OP_DEC_A       = 8'h14;
  localparam logic [7:0] OP_ADD_IMM     = 8'h24;
  localparam logic [7:0] OP_SUBB        = 8'h94;
  localparam logic [7:0] OP_ORL         = 8'h44;
  localparam logic [7:0] OP_ANL         = 8'h54;
  localparam logic [7:0] OP_XRL         = 8'h64;
  localparam logic [7:0] OP_JZ          = 8'h60;
  localparam logic [7:0] OP_JNZ         = 8'h70;
  localparam logic [7:0] OP_SJMP        = 8'h80;
  localparam logic [7:0] OP_MOV_A_IMM   = 8'h74;
  localparam logic [7:0] OP_MOV_DIR_IMM = 8'h75;
  localparam logic [7:0] OP_MOV_DPTR    = 8'h90;
  localparam logic [7:0] OP_INC_DPTR    = 8'hA3;
  localparam logic [7:0] OP_CJNE        = 8'hB4;
  localparam logic [7:0] OP_CLR_A       = 8'hE4;
  localparam logic [7:0] OP_CPL_A       = 8'hF4;
  localparam logic [7:0] OP_MOV_A_DIR   = 8'hE5;
  localparam logic [7:0] OP_MOV_DIR_A   = 8'hF5;
  localparam logic [7:0] OP_MOVX_RD     = 8'hE0;
  localparam logic [7:0] OP_MOVX_WR     = 8'hF0;

  // Register-addressed groups, matched on opcode[7:3]
  localparam logic [4:0] OPG_INC_RN     = 5'b00001;
  localparam logic [4:0] OPG_ADD_RN     = 5'b00101;
  localparam logic [4:0] OPG_MOV_RN_IMM = 5'b01111;
  localparam logic [4:0] OPG_DJNZ       = 5'b11011;
  localparam logic [4:0] OPG_MOV_A_RN   = 5'b11101;
  localparam logic [4:0] OPG_MOV_RN_A   = 5'b11111;

  localparam logic [7:0] SFR_P0  = 8'h80;
  localparam logic [7:0] SFR_SP  = 8'h81;
  localparam logic [7:0] SFR_DPL = 8'h82;
  localparam logic [7:0] SFR_DPH = 8'h83;
  localparam logic [7:0] SFR_P1  = 8'h90;
  localparam logic [7:0] SFR_P2  = 8'hA0;
  localparam logic [7:0] SFR_P3  = 8'hB0;
  localparam logic [7:0] SFR_PSW = 8'hD0;
  localparam logic [7:0] SFR_ACC = 8'hE0;
  localparam logic [7:0] SFR_B   = 8'hF0;

  localparam int unsigned PSW_CY  = 7;
  localparam int unsigned PSW_AC  = 6;
  localparam int unsigned PSW_RS1 = 4;
  localparam int unsigned PSW_RS0 = 3;
  localparam int unsigned PSW_OV  = 2;

  // Instruction length in bytes, decoded from the opcode
  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic [1:0] len;
    len = 2'd1;
    case (op)
      OP_LJMP, OP_LCALL, OP_MOV_DIR_IMM, OP_MOV_DPTR, OP_CJNE: len = 2'd3;
      OP_ADD_IMM, OP_SUBB, OP_ORL, OP_ANL, OP_XRL, OP_JZ, OP_JNZ, OP_SJMP,
      OP_MOV_A_IMM, OP_MOV_A_DIR, OP_MOV_DIR_A: len = 2'd2;
      default: begin
        if (op[7:3] == OPG_MOV_RN_IMM || op[7:3] == OPG_DJNZ) len = 2'd2;
      end
    endcase
    return len;
  endfunction

endpackage

// File: rtl/mcs51_alu.sv
// Combinational accumulator ALU: arithmetic with CY/AC/OV, logic and unary ops.
module mcs51_alu
  import mcs51_pkg::*;
(
  input  alu_op_t     op,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        cy_in,
  output logic [7:0]  result,
  output logic        cy,
  output logic        ac,
  output logic        ov
);

  logic [8:0] sum9;
  logic [8:0] diff9;
  logic [4:0] nib_sum;
  logic [4:0] nib_diff;

  always_comb begin
    result   = a;
    cy       = cy_in;
    ac       = 1'b0;
    ov       = 1'b0;
    sum9     = 9'(a) + 9'(b);
    diff9    = 9'(a) - 9'(b) - 9'(cy_in);
    nib_sum  = 5'(a[3:0]) + 5'(b[3:0]);
    nib_diff = 5'(a[3:0]) - 5'(b[3:0]) - 5'(cy_in);
    case (op)
      ALU_ADD: begin
        result = sum9[7:0];
        cy     = sum9[8];
        ac     = nib_sum[4];
        ov     = (a[7] == b[7]) && (sum9[7] != a[7]);
      end
      // Bit 8/bit 4 of the wrapped difference are the borrows
      ALU_SUBB: begin
        result = diff9[7:0];
        cy     = diff9[8];
        ac     = nib_diff[4];
        ov     = (a[7] != b[7]) && (diff9[7] != a[7]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_INC: result = a + 8'd1;
      ALU_DEC: result = a - 8'd1;
      ALU_CPL: result = ~a;
      default: result = a;
    endcase
  end

endmodule

// File: rtl/mcs51_mcu.sv
// Multi-cycle MCS-51 subset MCU: core FSM, code ROM, IRAM, XDATA and four ports.
module mcs51_mcu
  import mcs51_pkg::*;
#(
  parameter int unsigned IRAM_SIZE      = 128,
  parameter int unsigned CODE_SIZE      = 65536,
  parameter int unsigned XDATA_SIZE     = 65536,
  parameter string       CODE_INIT_FILE = ""
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] p0_in,
  input  logic [7:0] p1_in,
  input  logic [7:0] p2_in,
  input  logic [7:0] p3_in,
  output logic [7:0] p0_out,
  output logic [7:0] p1_out,
  output logic [7:0] p2_out,
  output logic [7:0] p3_out,
  output logic [7:0] p0_oe,
  output logic [7:0] p1_oe,
  output logic [7:0] p2_oe,
  output logic [7:0] p3_oe
);

  localparam int unsigned IRAM_AW  = $clog2(IRAM_SIZE);
  localparam int unsigned CODE_AW  = $clog2(CODE_SIZE);
  localparam int unsigned XDATA_AW = $clog2(XDATA_SIZE);

  logic [7:0] code_mem  [CODE_SIZE];
  logic [7:0] xdata_mem [XDATA_SIZE];
  logic [7:0] iram      [IRAM_SIZE];

  state_t          state_q, state_d;
  logic [15:0]     pc_q, pc_d;
  logic [7:0]      ir_q, ir_d, op1_q, op1_d, op2_q, op2_d;
  logic [7:0]      sp_q, sp_d, acc_q, acc_d, b_q, b_d, dpl_q, dpl_d, dph_q, dph_d;
  logic [7:1]      psw_q, psw_d;
  logic [3:0][7:0] port_q, port_d, oe_q;

  logic [15:0]        dptr, rel_tgt;
  logic [7:0]         code_byte, rn_val, dir_rd, psw_rd, rel, rn_dec, sp_inc1, sp_inc2, sp_dec1;
  logic [IRAM_AW-1:0] rn_addr;
  logic               iram_we, xdata_we, dir_we;
  logic [IRAM_AW-1:0] iram_wa;
  logic [7:0]         iram_wd, dir_wd;

  alu_op_t    alu_op;
  logic [7:0] alu_b, alu_res;
  logic       alu_cy, alu_ac, alu_ov;

  assign dptr      = {dph_q, dpl_q};
  assign code_byte = code_mem[pc_q[CODE_AW-1:0]];
  assign rn_addr   = IRAM_AW'({psw_q[PSW_RS1], psw_q[PSW_RS0], ir_q[2:0]});
  assign rn_val    = iram[rn_addr];
  assign rn_dec    = rn_val - 8'd1;
  assign psw_rd    = {psw_q, ^acc_q};
  assign sp_inc1   = sp_q + 8'd1;
  assign sp_inc2   = sp_q + 8'd2;
  assign sp_dec1   = sp_q - 8'd1;
  assign rel       = (ir_q == OP_CJNE) ? op2_q : op1_q;
  assign rel_tgt   = pc_q + {{8{rel[7]}}, rel};

  // Direct-address read: IRAM below 0x80, SFR space above
  always_comb begin
    dir_rd = 8'h00;
    if (!op1_q[7]) begin
      dir_rd = iram[op1_q[IRAM_AW-1:0]];
    end else begin
      case (op1_q)
        SFR_P0:  dir_rd = p0_in;
        SFR_SP:  dir_rd = sp_q;
        SFR_DPL: dir_rd = dpl_q;
        SFR_DPH: dir_rd = dph_q;
        SFR_P1:  dir_rd = p1_in;
        SFR_P2:  dir_rd = p2_in;
        SFR_P3:  dir_rd = p3_in;
        SFR_PSW: dir_rd = psw_rd;
        SFR_ACC: dir_rd = acc_q;
        SFR_B:   dir_rd = b_q;
        default: dir_rd = 8'h00;
      endcase
    end
  end

  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = op1_q;
    case (ir_q)
      OP_INC_A: alu_op = ALU_INC;
      OP_DEC_A: alu_op = ALU_DEC;
      OP_SUBB:  alu_op = ALU_SUBB;
      OP_ORL:   alu_op = ALU_OR;
      OP_ANL:   alu_op = ALU_AND;
      OP_XRL:   alu_op = ALU_XOR;
      OP_CPL_A: alu_op = ALU_CPL;
      default: begin
        if (ir_q[7:3] == OPG_ADD_RN) alu_b = rn_val;
      end
    endcase
  end

  mcs51_alu u_alu (
    .op     (alu_op),
    .a      (acc_q),
    .b      (alu_b),
    .cy_in  (psw_q[PSW_CY]),
    .result (alu_res),
    .cy     (alu_cy),
    .ac     (alu_ac),
    .ov     (alu_ov)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    sp_d     = sp_q;
    acc_d    = acc_q;
    b_d      = b_q;
    psw_d    = psw_q;
    dpl_d    = dpl_q;
    dph_d    = dph_q;
    port_d   = port_q;
    iram_we  = 1'b0;
    iram_wa  = '0;
    iram_wd  = 8'h00;
    xdata_we = 1'b0;
    dir_we   = 1'b0;
    dir_wd   = 8'h00;
    case (state_q)
      FETCH: begin
        ir_d    = code_byte;
        pc_d    = pc_q + 16'd1;
        state_d = (op_len(code_byte) == 2'd1) ? EXEC : OPND1;
      end
      OPND1: begin
        op1_d   = code_byte;
        pc_d    = pc_q + 16'd1;
        state_d = (op_len(ir_q) == 2'd3) ? OPND2 : EXEC;
      end
      OPND2: begin
        op2_d   = code_byte;
        pc_d    = pc_q + 16'd1;
        state_d = EXEC;
      end
      EXEC: begin
        state_d = FETCH;
        case (ir_q)
          OP_LJMP: pc_d = {op1_q, op2_q};
          OP_LCALL: begin
            iram_we = 1'b1;
            iram_wa = sp_inc1[IRAM_AW-1:0];
            iram_wd = pc_q[7:0];
            state_d = STK2;
          end
          OP_RET: begin
            pc_d[15:8] = iram[sp_q[IRAM_AW-1:0]];
            state_d    = STK2;
          end
          OP_INC_A, OP_DEC_A, OP_ORL, OP_ANL, OP_XRL, OP_CPL_A: acc_d = alu_res;
          OP_ADD_IMM, OP_SUBB: begin
            acc_d         = alu_res;
            psw_d[PSW_CY] = alu_cy;
            psw_d[PSW_AC] = alu_ac;
            psw_d[PSW_OV] = alu_ov;
          end
          OP_JZ:          if (acc_q == 8'h00) pc_d = rel_tgt;
          OP_JNZ:         if (acc_q != 8'h00) pc_d = rel_tgt;
          OP_SJMP:        pc_d = rel_tgt;
          OP_MOV_A_IMM:   acc_d = op1_q;
          OP_MOV_DIR_IMM: begin
            dir_we = 1'b1;
            dir_wd = op2_q;
          end
          OP_MOV_DPTR: begin
            dph_d = op1_q;
            dpl_d = op2_q;
          end
          OP_INC_DPTR:    {dph_d, dpl_d} = dptr + 16'd1;
          OP_CJNE: begin
            psw_d[PSW_CY] = (acc_q < op1_q);
            if (acc_q != op1_q) pc_d = rel_tgt;
          end
          OP_CLR_A:       acc_d = 8'h00;
          OP_MOV_A_DIR:   acc_d = dir_rd;
          OP_MOV_DIR_A: begin
            dir_we = 1'b1;
            dir_wd = acc_q;
          end
          OP_MOVX_RD:     acc_d = xdata_mem[dptr[XDATA_AW-1:0]];
          OP_MOVX_WR:     xdata_we = 1'b1;
          default: begin
            case (ir_q[7:3])
              OPG_INC_RN: begin
                iram_we = 1'b1;
                iram_wa = rn_addr;
                iram_wd = rn_val + 8'd1;
              end
              OPG_ADD_RN: begin
                acc_d         = alu_res;
                psw_d[PSW_CY] = alu_cy;
                psw_d[PSW_AC] = alu_ac;
                psw_d[PSW_OV] = alu_ov;
              end
              OPG_MOV_RN_IMM: begin
                iram_we = 1'b1;
                iram_wa = rn_addr;
                iram_wd = op1_q;
              end
              OPG_DJNZ: begin
                iram_we = 1'b1;
                iram_wa = rn_addr;
                iram_wd = rn_dec;
                if (rn_dec != 8'h00) pc_d = rel_tgt;
              end
              OPG_MOV_A_RN: acc_d = rn_val;
              OPG_MOV_RN_A: begin
                iram_we = 1'b1;
                iram_wa = rn_addr;
                iram_wd = acc_q;
              end
              default: ;
            endcase
          end
        endcase
        // Direct write lands last so it overrides any implicit ACC/PSW update
        if (dir_we) begin
          if (!op1_q[7]) begin
            iram_we = 1'b1;
            iram_wa = op1_q[IRAM_AW-1:0];
            iram_wd = dir_wd;
          end else begin
            case (op1_q)
              SFR_P0:  port_d[0] = dir_wd;
              SFR_SP:  sp_d      = dir_wd;
              SFR_DPL: dpl_d     = dir_wd;
              SFR_DPH: dph_d     = dir_wd;
              SFR_P1:  port_d[1] = dir_wd;
              SFR_P2:  port_d[2] = dir_wd;
              SFR_P3:  port_d[3] = dir_wd;
              SFR_PSW: psw_d     = dir_wd[7:1];
              SFR_ACC: acc_d     = dir_wd;
              SFR_B:   b_d       = dir_wd;
              default: ;
            endcase
          end
        end
      end
      STK2: begin
        state_d = FETCH;
        if (ir_q == OP_LCALL) begin
          iram_we = 1'b1;
          iram_wa = sp_inc2[IRAM_AW-1:0];
          iram_wd = pc_q[15:8];
          sp_d    = sp_inc2;
          pc_d    = {op1_q, op2_q};
        end else begin
          pc_d[7:0] = iram[sp_dec1[IRAM_AW-1:0]];
          sp_d      = sp_q - 8'd2;
        end
      end
      default: state_d = FETCH;
    endcase
    // An instruction cut short by reset must not leave a partial memory write
    if (reset) begin
      iram_we  = 1'b0;
      xdata_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= 16'h0000;
      ir_q    <= OP_NOP;
      op1_q   <= 8'h00;
      op2_q   <= 8'h00;
      sp_q    <= 8'h07;
      acc_q   <= 8'h00;
      b_q     <= 8'h00;
      psw_q   <= '0;
      dpl_q   <= 8'h00;
      dph_q   <= 8'h00;
      port_q  <= {4{8'hFF}};
      oe_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      sp_q    <= sp_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      psw_q   <= psw_d;
      dpl_q   <= dpl_d;
      dph_q   <= dph_d;
      port_q  <= port_d;
      oe_q    <= ~port_d;
    end
  end

  always_ff @(posedge clk) begin
    if (iram_we) iram[iram_wa] <= iram_wd;
    if (xdata_we) xdata_mem[dptr[XDATA_AW-1:0]] <= acc_q;
  end

  assign p0_out = port_q[0];
  assign p1_out = port_q[1];
  assign p2_out = port_q[2];
  assign p3_out = port_q[3];
  assign p0_oe  = oe_q[0];
  assign p1_oe  = oe_q[1];
  assign p2_oe  = oe_q[2];
  assign p3_oe  = oe_q[3];

endmodule

// File: tb/tb_mcs51_mcu.sv
// Directed-program bench for mcs51_mcu: expected XDATA writes are queued per program
// and matched by a monitor; architectural state is also checked at fixed cycle points.
module tb_mcs51_mcu;
  import mcs51_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] p0_in = 8'h00, p1_in = 8'h00, p2_in = 8'h00, p3_in = 8'h00;
  logic [7:0] p0_out, p1_out, p2_out, p3_out;
  logic [7:0] p0_oe, p1_oe, p2_oe, p3_oe;

  mcs51_mcu dut (
    .clk(clk), .reset(reset),
    .p0_in(p0_in), .p1_in(p1_in), .p2_in(p2_in), .p3_in(p3_in),
    .p0_out(p0_out), .p1_out(p1_out), .p2_out(p2_out), .p3_out(p3_out),
    .p0_oe(p0_oe), .p1_oe(p1_oe), .p2_oe(p2_oe), .p3_oe(p3_oe)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] prog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [15:0] a, input logic [7:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic load(input logic [7:0] bytes[$], input int unsigned base);
    for (int i = 0; i < bytes.size(); i++) dut.code_mem[16'(base + i)] = bytes[i];
  endtask

  task automatic clear_code(input int unsigned n);
    for (int i = 0; i < n; i++) dut.code_mem[i] = 8'h00;
  endtask

  task automatic hold_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: %0d writes outstanding after %0d cycles", name, exp_q.size(), n);
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: every XDATA write the DUT presents must match the next queued expectation
  always @(negedge clk) begin
    if (dut.xdata_we) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL xwr_unexpected: got addr %h data %h expected no write",
                 {dut.dph_q, dut.dpl_q}, dut.acc_q);
      end else begin
        mon_e = exp_q.pop_front();
        chk("xwr_addr", 32'({dut.dph_q, dut.dpl_q}), 32'(mon_e.a));
        chk("xwr_data", 32'(dut.acc_q), 32'(mon_e.d));
      end
    end
  end

  initial begin
    clear_code(65536);

    // Reset state and NOP throughput
    hold_reset();
    release_reset();
    chk("rst_pc", 32'(dut.pc_q), 32'h0000);
    chk("rst_sp", 32'(dut.sp_q), 32'h07);
    chk("rst_acc", 32'(dut.acc_q), 32'h00);
    chk("rst_psw", 32'(dut.psw_q), 32'h00);
    chk("rst_dptr", 32'({dut.dph_q, dut.dpl_q}), 32'h0000);
    chk("rst_state", 32'(dut.state_q), 32'(FETCH));
    chk("rst_pout", 32'({p0_out, p1_out, p2_out, p3_out}), 32'hFFFFFFFF);
    chk("rst_poe", 32'({p0_oe, p1_oe, p2_oe, p3_oe}), 32'h00000000);
    repeat (100) @(posedge clk);
    #1;
    chk("nop_pc", 32'(dut.pc_q), 32'd50);
    chk("nop_sp", 32'(dut.sp_q), 32'h07);
    chk("nop_pout", 32'({p0_out, p1_out, p2_out, p3_out}), 32'hFFFFFFFF);
    chk("nop_poe", 32'({p0_oe, p1_oe, p2_oe, p3_oe}), 32'h00000000);

    // ADD with carry/aux-carry, then PSW readback and done flag
    hold_reset();
    clear_code(256);
    dut.xdata_mem[16'hFFFE] = 8'h00;
    prog = '{8'h74, 8'h3C, 8'h24, 8'hC8, 8'h90, 8'h01, 8'h00, 8'hF0,
             8'hE5, 8'hD0, 8'h90, 8'h01, 8'h01, 8'hF0,
             8'h90, 8'hFF, 8'hFE, 8'h74, 8'hA5, 8'hF0, 8'h80, 8'hFE};
    load(prog, 0);
    expect_wr(16'h0100, 8'h04);
    expect_wr(16'h0101, 8'hC1);
    expect_wr(16'hFFFE, 8'hA5);
    release_reset();
    drain("add", 300);
    chk("add_x0100", 32'(dut.xdata_mem[16'h0100]), 32'h04);
    chk("add_done", 32'(dut.xdata_mem[16'hFFFE]), 32'hA5);

    // SUBB with borrow
    hold_reset();
    clear_code(256);
    dut.xdata_mem[16'hFFFE] = 8'h00;
    prog = '{8'h74, 8'h10, 8'h94, 8'h20, 8'h90, 8'h02, 8'h00, 8'hF0,
             8'hE5, 8'hD0, 8'h90, 8'h02, 8'h01, 8'hF0,
             8'h90, 8'hFF, 8'hFE, 8'h74, 8'hA5, 8'hF0, 8'h80, 8'hFE};
    load(prog, 0);
    expect_wr(16'h0200, 8'hF0);
    expect_wr(16'h0201, 8'h80);
    expect_wr(16'hFFFE, 8'hA5);
    release_reset();
    drain("subb", 300);
    chk("subb_done", 32'(dut.xdata_mem[16'hFFFE]), 32'hA5);

    // DJNZ loop: three iterations of INC A
    hold_reset();
    clear_code(256);
    prog = '{8'h78, 8'h03, 8'h04, 8'hD8, 8'hFD, 8'h90, 8'h03, 8'h00, 8'hF0,
             8'hE8, 8'h90, 8'h03, 8'h01, 8'hF0, 8'h80, 8'hFE};
    load(prog, 0);
    expect_wr(16'h0300, 8'h03);
    expect_wr(16'h0301, 8'h00);
    release_reset();
    drain("djnz", 300);

    // LCALL / RET with exact cycle timing
    hold_reset();
    clear_code(256);
    dut.iram[8] = 8'hFF;
    dut.iram[9] = 8'hFF;
    prog = '{8'h12, 8'h00, 8'h20, 8'h90, 8'h04, 8'h00, 8'hE5, 8'h81, 8'hF0,
             8'hE5, 8'h08, 8'h90, 8'h04, 8'h01, 8'hF0, 8'h80, 8'hFE};
    load(prog, 0);
    prog = '{8'h22};
    load(prog, 16'h0020);
    expect_wr(16'h0400, 8'h07);
    expect_wr(16'h0401, 8'h03);
    release_reset();
    repeat (5) @(posedge clk);
    #1;
    chk("call_pc", 32'(dut.pc_q), 32'h0020);
    chk("call_sp", 32'(dut.sp_q), 32'h09);
    repeat (3) @(posedge clk);
    #1;
    chk("ret_pc", 32'(dut.pc_q), 32'h0003);
    chk("ret_sp", 32'(dut.sp_q), 32'h07);
    chk("ret_iram8", 32'(dut.iram[8]), 32'h03);
    chk("ret_iram9", 32'(dut.iram[9]), 32'h00);
    drain("call", 300);

    // Port latch write and pin read with parity
    hold_reset();
    clear_code(256);
    p1_in = 8'h3C;
    prog = '{8'h75, 8'h90, 8'h5A, 8'hE5, 8'h90, 8'h90, 8'h05, 8'h00, 8'hF0,
             8'hE5, 8'hD0, 8'h90, 8'h05, 8'h01, 8'hF0, 8'h80, 8'hFE};
    load(prog, 0);
    expect_wr(16'h0500, 8'h3C);
    expect_wr(16'h0501, 8'h00);
    release_reset();
    drain("port", 300);
    chk("port_p1out", 32'(p1_out), 32'h5A);
    chk("port_p1oe", 32'(p1_oe), 32'hA5);
    chk("port_p0out", 32'(p0_out), 32'hFF);

    // Logic ops, CJNE carry and branch, JZ/JNZ, CPL
    hold_reset();
    clear_code(256);
    prog = '{8'h74, 8'h5A, 8'h54, 8'h0F, 8'h44, 8'h30, 8'h64, 8'hFF,
             8'h90, 8'h07, 8'h00, 8'hF0, 8'hB4, 8'hC6, 8'h02, 8'h74, 8'h00,
             8'hE5, 8'hD0, 8'h90, 8'h07, 8'h01, 8'hF0, 8'h60, 8'h02, 8'h70, 8'h02,
             8'h74, 8'h11, 8'hF4, 8'h90, 8'h07, 8'h02, 8'hF0, 8'h80, 8'hFE};
    load(prog, 0);
    expect_wr(16'h0700, 8'hC5);
    expect_wr(16'h0701, 8'h80);
    expect_wr(16'h0702, 8'h7F);
    release_reset();
    drain("logic", 400);

    // Reset during the EXEC of a MOVX write must suppress the write
    hold_reset();
    clear_code(256);
    dut.xdata_mem[16'h0600] = 8'h00;
    prog = '{8'h90, 8'h06, 8'h00, 8'h74, 8'h77, 8'hF0, 8'h80, 8'hFE};
    load(prog, 0);
    release_reset();
    begin
      bit found;
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
        @(posedge clk);
        #1;
        if (dut.state_q == EXEC && dut.ir_q == OP_MOVX_WR) found = 1'b1;
      end
      chk("abort_reach_exec", 32'(found), 32'd1);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_xdata", 32'(dut.xdata_mem[16'h0600]), 32'h00);
    chk("abort_pc", 32'(dut.pc_q), 32'h0000);
    chk("abort_state", 32'(dut.state_q), 32'(FETCH));
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
